// File: rtl/alu_core_reg.sv
// alu_core_reg: 32-bit two-operand ALU with a 64-bit registered result.
// sel chooses one of 16 operations, and each one is defined.
// The result appears on Yout one clock after A, B and sel are sampled.
// Division and modulo are purely combinational and finish in a single cycle.
module alu_core_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  sel,
   output logic [63:0] Yout
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_MUL  = 4'b0010,
      OP_DIV  = 4'b0011,
      OP_MOD  = 4'b0100,
      OP_AND  = 4'b0101,
      OP_OR   = 4'b0110,
      OP_XOR  = 4'b0111,
      OP_NAND = 4'b1000,
      OP_NOR  = 4'b1001,
      OP_XNOR = 4'b1010,
      OP_NOT  = 4'b1011,
      OP_SHL  = 4'b1100,
      OP_SHR  = 4'b1101,
      OP_GT   = 4'b1110,
      OP_CAT  = 4'b1111
   } op_e;

   op_e         op;
   logic [63:0] a_zx;
   logic [63:0] b_zx;
   logic [5:0]  shamt;
   logic [63:0] result;

   assign op    = op_e'(sel);
   assign a_zx  = {32'h0, A};
   assign b_zx  = {32'h0, B};
   // Only the low 6 bits of B set the shift distance, so the range is 0..63.
   assign shamt = B[5:0];

   // Combinational result for the current operands and opcode.
   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = a_zx + b_zx;
         OP_SUB:  result = a_zx - b_zx;
         OP_MUL:  result = a_zx * b_zx;
         OP_DIV:  result = (B == 32'h0) ? '1 : {32'h0, A / B};
         OP_MOD:  result = (B == 32'h0) ? a_zx : {32'h0, A % B};
         OP_AND:  result = {32'h0, A & B};
         OP_OR:   result = {32'h0, A | B};
         OP_XOR:  result = {32'h0, A ^ B};
         OP_NAND: result = {32'h0, ~(A & B)};
         OP_NOR:  result = {32'h0, ~(A | B)};
         OP_XNOR: result = {32'h0, ~(A ^ B)};
         OP_NOT:  result = {32'h0, ~A};
         OP_SHL:  result = a_zx << shamt;
         OP_SHR:  result = a_zx >> shamt;
         OP_GT:   result = {63'h0, (A > B)};
         OP_CAT:  result = {A, B};
         default: result = '0;
      endcase
   end

   // Output register; synchronous reset takes priority over loading a result.
   always_ff @(posedge clk) begin
      if (rst) begin
         Yout <= '0;
      end else begin
         Yout <= result;
      end
   end

endmodule

// File: tb/tb_alu_core_reg.sv
// tb_alu_core_reg: directed vectors with hand-computed expectations.
// The driver queues each expected result; a monitor pops and checks one per clock.
module tb_alu_core_reg;

   logic        clk;
   logic        rst;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  sel;
   logic [63:0] Yout;

   typedef struct {
      logic [63:0] exp;
      string       name;
   } item_t;

   item_t sb[$];
   int    total;
   int    bad;

   alu_core_reg dut (
      .clk  (clk),
      .rst  (rst),
      .A    (A),
      .B    (B),
      .sel  (sel),
      .Yout (Yout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs on the falling edge and queue the result expected at the next rising edge.
   task automatic issue(input logic r, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] s, input logic [63:0] exp, input string name);
      item_t it;
      @(negedge clk);
      rst = r;
      A   = a;
      B   = b;
      sel = s;
      it.exp  = exp;
      it.name = name;
      sb.push_back(it);
   endtask

   // Monitor: there is no valid signal, so one result is checked every clock while items are pending.
   initial begin
      item_t it;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            it = sb.pop_front();
            total++;
            if (Yout !== it.exp) begin
               bad++;
               $display("FAIL %s: got %h expected %h", it.name, Yout, it.exp);
            end
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1; A = '0; B = '0; sel = '0;

      // Reset held for two cycles, then released.
      issue(1'b1, 32'd16, 32'd8, 4'b0010, 64'd0,   "rst_0");
      issue(1'b1, 32'd16, 32'd8, 4'b0010, 64'd0,   "rst_1");
      issue(1'b0, 32'd16, 32'd8, 4'b0010, 64'd128, "mul_after_rst");

      // Arithmetic sweep.
      issue(1'b0, 32'h10, 32'h8, 4'b0000, 64'd24,  "add");
      issue(1'b0, 32'h10, 32'h8, 4'b0001, 64'd8,   "sub");
      issue(1'b0, 32'h10, 32'h8, 4'b0010, 64'd128, "mul");
      issue(1'b0, 32'h10, 32'h8, 4'b0011, 64'd2,   "div");
      issue(1'b0, 32'h10, 32'h8, 4'b0100, 64'd0,   "mod");

      // Logic sweep.
      issue(1'b0, 32'h10, 32'h8, 4'b0101, 64'd0,                   "and");
      issue(1'b0, 32'h10, 32'h8, 4'b0110, 64'd24,                  "or");
      issue(1'b0, 32'h10, 32'h8, 4'b0111, 64'd24,                  "xor");
      issue(1'b0, 32'h10, 32'h8, 4'b1000, 64'h0000_0000_FFFF_FFFF, "nand");
      issue(1'b0, 32'h10, 32'h8, 4'b1001, 64'h0000_0000_FFFF_FFE7, "nor");
      issue(1'b0, 32'h10, 32'h8, 4'b1010, 64'h0000_0000_FFFF_FFE7, "xnor");
      issue(1'b0, 32'h10, 32'h8, 4'b1011, 64'h0000_0000_FFFF_FFEF, "not");

      // Shift, compare and concatenate.
      issue(1'b0, 32'h10, 32'h8,  4'b1100, 64'd4096,                "shl");
      issue(1'b0, 32'h10, 32'h8,  4'b1101, 64'd0,                   "shr");
      issue(1'b0, 32'h10, 32'h8,  4'b1110, 64'd1,                   "gt_true");
      issue(1'b0, 32'h10, 32'h8,  4'b1111, 64'h0000_0010_0000_0008, "cat");
      issue(1'b0, 32'h8,  32'h10, 4'b1110, 64'd0,                   "gt_false");
      issue(1'b0, 32'd5,  32'd5,  4'b1110, 64'd0,                   "gt_equal");

      // Boundary cases.
      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 64'h0000_0001_FFFF_FFFE, "add_carry");
      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0010, 64'hFFFF_FFFE_0000_0001, "mul_max");
      issue(1'b0, 32'd0,         32'd1,         4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, "sub_wrap");
      issue(1'b0, 32'd1,         32'd63,        4'b1100, 64'h8000_0000_0000_0000, "shl_63");
      issue(1'b0, 32'd1,         32'h40,        4'b1100, 64'd1,                   "shl_ign_hi");
      issue(1'b0, 32'h8000_0000, 32'hFFFF_FFC4, 4'b1101, 64'h0000_0000_0800_0000, "shr_ign_hi");
      issue(1'b0, 32'hFFFF_FFFF, 32'd32,        4'b1100, 64'hFFFF_FFFF_0000_0000, "shl_32");
      issue(1'b0, 32'd100,       32'd7,         4'b0011, 64'd14,                  "div_100_7");
      issue(1'b0, 32'd100,       32'd7,         4'b0100, 64'd2,                   "mod_100_7");

      // Divide by zero, with a reset pulse in the middle of the sequence.
      issue(1'b0, 32'd100, 32'd0, 4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, "div_by_0");
      issue(1'b1, 32'd100, 32'd0, 4'b0100, 64'd0,                   "rst_pulse");
      issue(1'b0, 32'd100, 32'd0, 4'b0100, 64'd100,                 "mod_by_0");

      // Let the monitor drain the queue, then confirm nothing is left pending.
      repeat (3) @(posedge clk);
      #2;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d expected 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_core_reg.md
Name: alu_core_reg

Overview:
32-bit two-operand arithmetic/logic unit with a 64-bit registered result, selected by a 4-bit opcode. It is used as the datapath execute element. Full-width multiply and operand concatenation both fit the 64-bit output without truncation. The output is registered with one cycle of latency.

Parameters:
None. Operand width is fixed at 32 bits, result width at 64 bits and opcode width at 4 bits.

Ports:
clk   input   1   rising-edge clock
rst   input   1   synchronous reset, active-high
A     input   32  operand A, unsigned
B     input   32  operand B, unsigned
sel   input   4   operation select
Yout  output  64  registered result

Behaviour:
- Timing
  - One clock domain; all state updates on the rising edge of clk.
  - rst=1 at a clock edge: Yout <= 64'h0 on that edge. Reset has priority over any operation.
  - Otherwise, every edge: Yout <= f(A, B, sel), sampled on that edge. Latency is exactly 1 cycle.
  - No enable and no handshake. A new operation may be issued every cycle.
  - Reset asserted mid-stream discards the pending result. The first edge after rst deasserts loads the current f(A, B, sel).
- Operands are unsigned. "zx" means zero-extend to 64 bits.
- Operation table:
  - 0000: ADD, zx(A) + zx(B). Carry appears in bit 32.
  - 0001: SUB, zx(A) - zx(B), taken mod 2^64. A<B yields the 64-bit two's-complement wrap, e.g. 0 - 1 = 64'hFFFF_FFFF_FFFF_FFFF.
  - 0010: MUL, zx(A) * zx(B). Full 64-bit unsigned product.
  - 0011: DIV, zx(A / B). If B=0: 64'hFFFF_FFFF_FFFF_FFFF.
  - 0100: MOD, zx(A % B). If B=0: zx(A).
  - 0101: AND, zx(A & B).
  - 0110: OR, zx(A | B).
  - 0111: XOR, zx(A ^ B).
  - 1000: NAND, zx(~(A & B)).
  - 1001: NOR, zx(~(A | B)).
  - 1010: XNOR, zx(~(A ^ B)).
  - 1011: NOT, zx(~A). B is ignored.
  - 1100: SHL, zx(A) << B[5:0]. 64-bit logical shift; B[31:6] are ignored.
  - 1101: SHR, zx(A) >> B[5:0]. Logical shift; zeros are shifted in.
  - 1110: GT, 64'd1 if A > B (unsigned), else 64'd0.
  - 1111: CAT, {A, B}, with A in bits [63:32] and B in bits [31:0].
- Result width rules
  - Logic operations (0101–1011) always have Yout[63:32] = 0.
  - Division and modulo are combinational. They must settle within one cycle, with no multicycle path.
- Sel changes: X on sel or operands is not required to be handled. Every one of the 16 codes is defined; there is no illegal opcode.

Test Plan:
- Reset: drive rst=1 for 2 cycles with A=16, B=8, sel=0010 -> Yout=0 throughout. Release rst -> Yout=128 one cycle later.
- Arithmetic sweep, A=32'h10, B=32'h8, sel stepped 0000..0100 one per cycle -> Yout sequence 24, 8, 128, 2, 0, each appearing 1 cycle after its sel.
- Logic sweep, same operands, sel 0101..1011:
  - AND 0, OR 24, XOR 24
  - NAND 64'h0000_0000_FFFF_FFFF
  - NOR 64'h0000_0000_FFFF_FFE7, XNOR 64'h0000_0000_FFFF_FFE7
  - NOT 64'h0000_0000_FFFF_FFEF
- Shift/compare/concat, same operands, sel 1100..1111:
  - SHL 4096, SHR 0, GT 1
  - CAT 64'h0000_0010_0000_0008
  - Repeat with A=8, B=16: GT -> 0.
- Boundaries:
  - A=32'hFFFF_FFFF, B=32'hFFFF_FFFF: ADD -> 64'h1_FFFF_FFFE; MUL -> 64'hFFFF_FFFE_0000_0001.
  - A=0, B=1: SUB -> 64'hFFFF_FFFF_FFFF_FFFF.
  - A=1, B=63: SHL -> 64'h8000_0000_0000_0000.
- Divide by zero: A=100, B=0 -> DIV gives 64'hFFFF_FFFF_FFFF_FFFF, MOD gives 100. A reset pulse issued mid-sequence forces Yout=0 for that cycle.
